// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the block-RAM backed FWFT FIFO.
package sync_fifo_pkg;

  localparam int DEF_ADDRESS_WIDTH = 10;

  // Occupancy counter for the default geometry; it must reach DEPTH itself, hence the extra bit.
  typedef logic [DEF_ADDRESS_WIDTH:0] occ_t;

  // Number of words held in the two prefetch stages (RAM read-data register and output register).
  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_ONE   = 2'd1,
    STG_TWO   = 2'd2
  } stg_occ_e;

  // Tiny FIFOs would get a threshold of zero or less, so they fall back to "almost full == full".
  function automatic int af_thresh_default(input int aw);
    int depth;
    depth = 2 ** aw;
    return (depth > 4) ? depth - 4 : depth;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple-dual-port RAM with a registered read port and no reset on storage.
module sync_fifo_mem #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     rd_en_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  // The controller never reads the address it is writing, so collision logic is unnecessary.
  (* no_rw_check *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_bram.sv
// Single-clock FWFT FIFO on an inferred SDP RAM with two prefetch stages.
// Define SYNC_FIFO_BRAM_STATS_EN to add overflow/underflow stickies and a high-water mark.
module sync_fifo_bram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int AF_THRESH     = af_thresh_default(ADDRESS_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [ADDRESS_WIDTH:0]  count,
  output logic                    almost_full
`ifdef SYNC_FIFO_BRAM_STATS_EN
  ,
  output logic                    overflow_sticky,
  output logic                    underflow_sticky,
  output logic [ADDRESS_WIDTH:0]  max_count
`endif
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH:0]   cnt_t;
  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;

  localparam cnt_t FULL_LVL = cnt_t'(DEPTH);
  localparam cnt_t AF_LVL   = cnt_t'(AF_THRESH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  ptr_t                  wptr_q, wptr_d;
  ptr_t                  rptr_q, rptr_d;
  cnt_t                  count_q, count_d;
  logic                  af_q, af_d;
  logic                  rdy_en_q;
  logic                  s1_valid_q, s1_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  logic                  push, pop, move, rd_en;
  logic [1:0]            stg_now;
  stg_occ_e              occ_after;
  cnt_t                  stg_wide;

  sync_fifo_mem #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wptr_q),
    .wr_data_i (s_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rptr_q),
    .rd_data_o (ram_rd_data)
  );

  // No pop-to-ready path: a full FIFO refuses the push even when the head leaves this cycle.
  assign s_ready = rdy_en_q && (count_q != FULL_LVL) && !flush;

  always_comb begin
    push      = s_valid && s_ready;
    pop       = out_valid_q && m_ready;
    stg_now   = {1'b0, s1_valid_q} + {1'b0, out_valid_q};
    occ_after = stg_occ_e'(stg_now - {1'b0, pop});
    stg_wide  = '0;
    stg_wide[1:0] = stg_now;
    move      = s1_valid_q && (!out_valid_q || pop);
    // Unread RAM words are everything counted that is not already sitting in a stage.
    rd_en     = (count_q != stg_wide) && (occ_after != STG_TWO) && !flush;

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    m_data_d    = m_data_q;

    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (rd_en) rptr_d = rptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      out_valid_d = move || (out_valid_q && !pop);
      s1_valid_d  = rd_en || (s1_valid_q && !move);
      if (move) m_data_d = ram_rd_data;
    end

    af_d = (count_d >= AF_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      af_q        <= 1'b0;
      rdy_en_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      m_data_q    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      af_q        <= af_d;
      rdy_en_q    <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      m_data_q    <= m_data_d;
    end
  end

  assign m_valid     = out_valid_q;
  assign m_data      = m_data_q;
  assign count       = count_q;
  assign almost_full = af_q;

`ifdef SYNC_FIFO_BRAM_STATS_EN
  logic ovf_q, unf_q;
  cnt_t max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      max_q <= '0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      max_q <= '0;
    end else begin
      if (s_valid && !s_ready && (count_q == FULL_LVL)) ovf_q <= 1'b1;
      if (m_ready && !out_valid_q) unf_q <= 1'b1;
      if (count_d > max_q) max_q <= count_d;
    end
  end

  assign overflow_sticky  = ovf_q;
  assign underflow_sticky = unf_q;
  assign max_count        = max_q;
`endif

endmodule

// File: tb/tb_sync_fifo_bram.sv
// Randomised checks of sync_fifo_bram (16-entry and 2-entry instances) against a queue model.
module tb_sync_fifo_bram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, s_valid, m_ready, sel;
  logic [7:0] s_data;

  logic       s_ready_a, m_valid_a, af_a;
  logic [7:0] m_data_a;
  logic [4:0] count_a;
  logic       s_ready_b, m_valid_b, af_b;
  logic [7:0] m_data_b;
  logic [1:0] count_b;
`ifdef SYNC_FIFO_BRAM_STATS_EN
  logic       ovf_a, unf_a, ovf_b, unf_b;
  logic [4:0] max_a;
  logic [1:0] max_b;
`endif

  sync_fifo_bram #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush && !sel),
    .s_valid     (s_valid && !sel),
    .s_ready     (s_ready_a),
    .s_data      (s_data),
    .m_valid     (m_valid_a),
    .m_ready     (m_ready && !sel),
    .m_data      (m_data_a),
    .count       (count_a),
    .almost_full (af_a)
`ifdef SYNC_FIFO_BRAM_STATS_EN
    ,
    .overflow_sticky  (ovf_a),
    .underflow_sticky (unf_a),
    .max_count        (max_a)
`endif
  );

  sync_fifo_bram #(.DATA_WIDTH(8), .ADDRESS_WIDTH(1), .AF_THRESH(1)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush && sel),
    .s_valid     (s_valid && sel),
    .s_ready     (s_ready_b),
    .s_data      (s_data),
    .m_valid     (m_valid_b),
    .m_ready     (m_ready && sel),
    .m_data      (m_data_b),
    .count       (count_b),
    .almost_full (af_b)
`ifdef SYNC_FIFO_BRAM_STATS_EN
    ,
    .overflow_sticky  (ovf_b),
    .underflow_sticky (unf_b),
    .max_count        (max_b)
`endif
  );

  // Observed outputs of whichever instance is under test.
  logic       o_s_ready, o_m_valid, o_af;
  logic [7:0] o_m_data;
  logic [4:0] o_count;
  assign o_s_ready = sel ? s_ready_b : s_ready_a;
  assign o_m_valid = sel ? m_valid_b : m_valid_a;
  assign o_af      = sel ? af_b : af_a;
  assign o_m_data  = sel ? m_data_b : m_data_a;
  assign o_count   = sel ? {3'b000, count_b} : count_a;

  // Reference model: stored words in order, each tagged with the edge it was pushed on.
  // A word is visible at the head once it is the oldest and at least two edges old.
  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;
  ent_t       mq[$];
  int         cyc;
  logic       rdy_m;
  logic       hold_m;
  logic [7:0] hold_d;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, take the edge, advance the model.
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr, input logic fl,
                      output logic pushed);
    logic exp_rdy, exp_mv, do_pop;
    int   depth, af;
    ent_t e;
    depth   = sel ? 2 : 16;
    af      = sel ? 1 : 12;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    exp_rdy = rdy_m && (mq.size() != depth) && !fl;
    exp_mv  = (mq.size() > 0) && ((cyc - mq[0].t) >= 2);
    chk("s_ready", 32'(o_s_ready), 32'(exp_rdy));
    chk("m_valid", 32'(o_m_valid), 32'(exp_mv));
    if (exp_mv) chk("m_data", 32'(o_m_data), 32'(mq[0].d));
    if (hold_m) chk("hold_m_data", 32'(o_m_data), 32'(hold_d));
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("almost_full", 32'(o_af), 32'(mq.size() >= af));
    pushed = sv && exp_rdy;
    do_pop = exp_mv && mr;
    hold_m = exp_mv && !mr && !fl;
    hold_d = o_m_data;
    @(posedge clk);
    cyc++;
    rdy_m = 1'b1;
    if (fl) begin
      mq.delete();
      $display("flush @%0d", cyc);
    end else begin
      if (do_pop) begin
        $display("pop  0x%02h @%0d", mq[0].d, cyc);
        mq.delete(0);
      end
      if (pushed) begin
        e.d = sd;
        e.t = cyc;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic p;
    int   pushed;
    int   n;
    sel = 1'b0; rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    cyc = 0; rdy_m = 1'b0; hold_m = 1'b0; hold_d = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_ready_a", 32'(s_ready_a), 32'd0);
    chk("rst_m_valid_a", 32'(m_valid_a), 32'd0);
    chk("rst_m_data_a", 32'(m_data_a), 32'd0);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_af_a", 32'(af_a), 32'd0);
    chk("rst_s_ready_b", 32'(s_ready_b), 32'd0);
    chk("rst_m_valid_b", 32'(m_valid_b), 32'd0);
    chk("rst_count_b", 32'(count_b), 32'd0);
    rst = 1'b0;

    // Basic: three words through an empty FIFO with the consumer always ready.
    step(1'b0, 8'h00, 1'b1, 1'b0, p);
    step(1'b1, 8'h11, 1'b1, 1'b0, p);
    step(1'b1, 8'h22, 1'b1, 1'b0, p);
    step(1'b1, 8'h33, 1'b1, 1'b0, p);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, p);

    // Fill to full, refused 17th word, push+pop at 16 then at 15, then drain.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, p);
    step(1'b1, 8'h99, 1'b0, 1'b0, p);
    chk("full_push_refused", 32'(p), 32'd0);
    step(1'b1, 8'h77, 1'b1, 1'b0, p);
    step(1'b1, 8'h10, 1'b1, 1'b0, p);
    chk("push_pop_at_15", 32'(p), 32'd1);
    repeat (20) step(1'b0, 8'h00, 1'b1, 1'b0, p);

    // Random backpressure over 1000 words.
    pushed = 0;
    n = 0;
    while ((pushed < 1000 || mq.size() != 0) && n < 20000) begin
      step((pushed < 1000) && ($urandom_range(0, 3) != 0), 8'($urandom),
           $urandom_range(0, 2) != 0, 1'b0, p);
      if (p) pushed++;
      n++;
    end
    chk("bp_drained_count", 32'(o_count), 32'd0);

    // Flush with seven words held and a write on the same edge.
    for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, p);
    step(1'b1, 8'hEE, 1'b0, 1'b1, p);
    step(1'b1, 8'hA5, 1'b0, 1'b0, p);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, p);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, p);

    // Two-entry instance: stream across pointer wrap.
    sel = 1'b1;
    hold_m = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, p);
    pushed = 0;
    n = 0;
    while ((pushed < 10 || mq.size() != 0) && n < 500) begin
      step((pushed < 10) && ($urandom_range(0, 3) != 0), 8'($urandom),
           $urandom_range(0, 2) != 0, 1'b0, p);
      if (p) pushed++;
      n++;
    end
    chk("wrap_drained_count", 32'(o_count), 32'd0);

    // Fill, push into full, then assert reset between edges.
    step(1'b1, 8'h5A, 1'b0, 1'b0, p);
    step(1'b1, 8'hC3, 1'b0, 1'b0, p);
    step(1'b1, 8'h3C, 1'b0, 1'b0, p);
    step(1'b0, 8'h00, 1'b0, 1'b0, p);
`ifdef SYNC_FIFO_BRAM_STATS_EN
    chk("max_count_pre_rst", 32'(max_b), 32'd2);
    chk("overflow_pre_rst", 32'(ovf_b), 32'd1);
`endif
    chk("pre_rst_m_valid", 32'(o_m_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_m_valid", 32'(o_m_valid), 32'd0);
    chk("async_count", 32'(o_count), 32'd0);
    chk("async_s_ready", 32'(o_s_ready), 32'd0);
`ifdef SYNC_FIFO_BRAM_STATS_EN
    chk("max_count_post_rst", 32'(max_b), 32'd0);
    chk("overflow_post_rst", 32'(ovf_b), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    rdy_m = 1'b0;
    hold_m = 1'b0;
    step(1'b1, 8'h42, 1'b1, 1'b0, p);
    step(1'b1, 8'h43, 1'b1, 1'b0, p);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, p);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
